ysyx_23060042_dmem_resp: RTL and testbench
==========================================

Name: ysyx_23060042_dmem_resp

Overview:
- Data-memory responder: the other end of the core's load/store path.
- Services load/store requests over a valid/ready request channel and returns read data (feeds the core's mrdata) over a valid/ready response channel.
- Internal word-organised storage with fixed programmable latency, byte-lane writes, and load lane-select with sign/zero extension.
- Replaces the zero-latency DPI memory so multi-cycle LSU behaviour can be exercised.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit storage words.
- BASE_ADDR, 32'h80000000, byte address of word 0.
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_addr  input  32  byte address.
- req_wen  input  1  1 = store, 0 = load.
- req_wdata  input  32  store data, already lane-aligned by the requester.
- req_wmask  input  4  store byte enables.
- req_size  input  2  load width: 00 none, 01 byte, 10 half, 11 word.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts response.
- rsp_rdata  output  32  extended load data; 0 for stores.

Behaviour:
- Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, latency counter 0. Storage is not cleared.
- Reset mid-operation aborts the transaction. An uncommitted store is never written.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch all request fields and load counter with LATENCY-1.
  - If LATENCY==1, go directly to RESP on the next edge.
  - Otherwise go to WAIT.
- WAIT: req_ready=0. Counter decrements each cycle. When counter reaches 1, the next edge enters RESP.
- Result: rsp_valid rises exactly LATENCY cycles after the accept edge.
- Transition into RESP:
  - Stores commit to storage on this edge, honouring mask bits per byte.
  - Loads sample storage and register the extended result into rsp_rdata on this edge.
- RESP: rsp_valid=1. rsp_rdata is held stable until rsp_valid&rsp_ready, then the FSM returns to IDLE.
  - No request is accepted in the same cycle as a response handshake.
  - Minimum issue interval is LATENCY+1 cycles.
- Address decode: index=(req_addr-BASE_ADDR)>>2.
  - In range iff req_addr>=BASE_ADDR and index<DEPTH_WORDS.
  - Out-of-range store is dropped. Out-of-range load returns 0. A response is still produced.
- Load extraction:
  - Byte: lane addr[1:0].
  - Half: lane addr[1], addr[0] ignored.
  - Word: addr[1:0] ignored.
  - Sign bit is bit 7/15 of the selected lane unless req_unsigned.
  - req_size 00 returns 0.
- Store with req_wmask=0: no storage change, normal response.
- Requests presented while req_ready=0 are ignored and are not latched.

Optional Feature:
- Macro: YSYX_23060042_DMEM_MISALIGN_CHK_EN.
- Defined: adds output rsp_err (1 bit, reset 0, valid with rsp_valid). Misaligned if half with addr[0]=1, or word with addr[1:0]!=0. On a misaligned access:
  - rsp_err=1.
  - The store is suppressed.
  - Load rdata=0.
  - Latency is unchanged.
- Undefined: the port is absent and low address bits are handled per the extraction rules.

Decomposition:
- Package ysyx_23060042_mem_pkg:
  - size enum (SZ_NONE, SZ_B, SZ_H, SZ_W).
  - FSM state enum (IDLE, WAIT, RESP).
  - Default BASE_ADDR constant.
- One natural combinational sub-module: ysyx_23060042_load_ext (word, addr[1:0], size, unsigned -> 32-bit extended data).

Test Plan:
- Reset asserted mid-WAIT of store 0xDEADBEEF@0x80000000 -> outputs return to reset values; a later word load of 0x80000000 does not return 0xDEADBEEF.
- LATENCY=2: store word 0x8899AABB@0x80000004 mask 1111 accepted at cycle 0 -> rsp_valid at cycle 2; word load of 0x80000004 returns 0x8899AABB.
- Then load byte @0x80000004, signed -> 0xFFFFFFBB; unsigned half @0x80000006 -> 0x00008899; signed half @0x80000006 -> 0xFFFF8899.
- Store 0x00110000 mask 0100 to 0x80000004, then word load -> 0x8811AABB.
- rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable throughout; req_ready=0 and a concurrent req_valid is not accepted.
- Load @0x7FFFFFFC and @BASE+4*DEPTH_WORDS -> rsp_rdata=0, response still given. With the macro defined, word load @0x80000002 -> rsp_err=1 and rdata=0.

Source files
------------

// File: rtl/ysyx_23060042_mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional misalignment checking is enabled by YSYX_23060042_DMEM_MISALIGN_CHK_EN.
package ysyx_23060042_mem_pkg;

  // Load width encoding as carried on req_size.
  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_B    = 2'b01,
    SZ_H    = 2'b10,
    SZ_W    = 2'b11
  } sz_e;

  // Responder transaction state.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  // Half accesses need addr[0]==0, word accesses need addr[1:0]==0.
  function automatic logic is_misaligned(input sz_e sz, input logic [1:0] lo);
    return ((sz == SZ_H) && lo[0]) || ((sz == SZ_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_23060042_dmem_resp_if.sv
// Request/response bus between a load/store unit (master) and the data-memory
// responder (slave). rsp_err exists only with YSYX_23060042_DMEM_MISALIGN_CHK_EN.
interface ysyx_23060042_dmem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
`ifdef YSYX_23060042_DMEM_MISALIGN_CHK_EN
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, req_size,
           req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, req_size,
           req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
`else
  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, req_size,
           req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, req_size,
           req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
`endif
endinterface

// File: rtl/ysyx_23060042_load_ext.sv
// Load lane select and sign/zero extension of a 32-bit storage word.
module ysyx_23060042_load_ext
  import ysyx_23060042_mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  sz_e         i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_lanes [4];
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lanes[gi] = i_word[gi*8 +: 8];
    end
  endgenerate

  // Pick the addressed byte and half; halves ignore addr[0].
  always_comb begin
    w_byte = w_lanes[i_lane];
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
  end

  // Extend the selected lane to 32 bits; size NONE yields zero.
  always_comb begin
    o_data = '0;
    case (i_size)
      SZ_B:    o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
      SZ_H:    o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
      SZ_W:    o_data = i_word;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060042_dmem_resp.sv
// Data-memory responder with fixed latency, byte-lane stores and extended loads.
// Define YSYX_23060042_DMEM_MISALIGN_CHK_EN to add misaligned-access detection
// (rsp_err, store suppressed, load data zeroed).
module ysyx_23060042_dmem_resp
  import ysyx_23060042_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          LATENCY     = 2   // legal range 1..15
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_23060042_dmem_resp_if.slave      bus
);

  localparam int         IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_e      r_state;
  state_e      w_state_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic        r_wen;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;
  sz_e         r_size;
  logic        r_unsigned;
  logic [31:0] r_rdata;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept;
  logic        w_enter_resp;
  logic [31:0] w_cur_addr;
  logic        w_cur_wen;
  logic [31:0] w_cur_wdata;
  logic [3:0]  w_cur_wmask;
  sz_e         w_cur_size;
  logic        w_cur_unsigned;
  logic [31:0] w_word_off;
  logic        w_in_range;
  logic        w_bad;
  logic        w_commit;
  logic [3:0]  w_lane_we;
  logic [31:0] w_rd_word;
  logic [31:0] w_ext;
  logic [31:0] w_load_data;

  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_rdata = r_rdata;
  assign w_accept      = bus.req_valid && bus.req_ready;

  // Next-state logic; w_enter_resp marks the edge that commits/samples storage.
  always_comb begin
    w_state_next = r_state;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_next = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_next = RESP;
          w_enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // With LATENCY==1 the RESP entry coincides with acceptance, so the live
  // request fields are used there instead of the latched copy.
  always_comb begin
    if (r_state == IDLE) begin
      w_cur_addr     = bus.req_addr;
      w_cur_wen      = bus.req_wen;
      w_cur_wdata    = bus.req_wdata;
      w_cur_wmask    = bus.req_wmask;
      w_cur_size     = sz_e'(bus.req_size);
      w_cur_unsigned = bus.req_unsigned;
    end else begin
      w_cur_addr     = r_addr;
      w_cur_wen      = r_wen;
      w_cur_wdata    = r_wdata;
      w_cur_wmask    = r_wmask;
      w_cur_size     = r_size;
      w_cur_unsigned = r_unsigned;
    end
  end

  assign w_word_off = (w_cur_addr - BASE_ADDR) >> 2;
  assign w_in_range = (w_cur_addr >= BASE_ADDR) && (w_word_off < 32'(DEPTH_WORDS));

`ifdef YSYX_23060042_DMEM_MISALIGN_CHK_EN
  logic r_err;

  assign w_bad       = is_misaligned(w_cur_size, w_cur_addr[1:0]);
  assign bus.rsp_err = r_err;

  // Error flag is captured alongside the response data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_enter_resp) begin
      r_err <= w_bad;
    end
  end
`else
  assign w_bad = 1'b0;
`endif

  // rst gating keeps an aborted store from landing even on a reset edge.
  assign w_commit = w_enter_resp && w_cur_wen && w_in_range && !w_bad && !rst;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_we
      assign w_lane_we[gi] = w_commit && w_cur_wmask[gi];
    end
  endgenerate

  assign w_rd_word = r_mem[w_word_off[IDX_W-1:0]];

  ysyx_23060042_load_ext u_load_ext (
    .i_word     (w_rd_word),
    .i_lane     (w_cur_addr[1:0]),
    .i_size     (w_cur_size),
    .i_unsigned (w_cur_unsigned),
    .o_data     (w_ext)
  );

  assign w_load_data = (!w_cur_wen && w_in_range && !w_bad) ? w_ext : 32'h0;

  // Storage: byte-lane writes, never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_lane_we[i]) r_mem[w_word_off[IDX_W-1:0]][i*8 +: 8] <= w_cur_wdata[i*8 +: 8];
    end
  end

  // State, latency counter, latched request and registered response data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= 32'h0;
      r_wen      <= 1'b0;
      r_wdata    <= 32'h0;
      r_wmask    <= 4'h0;
      r_size     <= SZ_NONE;
      r_unsigned <= 1'b0;
      r_rdata    <= 32'h0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_cnt      <= LAT_M1;
        r_addr     <= bus.req_addr;
        r_wen      <= bus.req_wen;
        r_wdata    <= bus.req_wdata;
        r_wmask    <= bus.req_wmask;
        r_size     <= sz_e'(bus.req_size);
        r_unsigned <= bus.req_unsigned;
      end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) r_rdata <= w_load_data;
    end
  end

endmodule

// File: tb/tb_ysyx_23060042_dmem_resp.sv
// Directed testbench for ysyx_23060042_dmem_resp (LATENCY=2, DEPTH_WORDS=1024).
module tb_ysyx_23060042_dmem_resp;

  localparam int          LAT   = 2;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  ysyx_23060042_dmem_resp_if bus ();

  ysyx_23060042_dmem_resp #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .LATENCY     (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full transaction; called and returns at posedge+1.
  task automatic xact(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                      input logic [3:0] wmask, input logic [1:0] size, input logic uns,
                      output logic [31:0] rdata, output int lat);
    int n;
    bus.req_addr     = addr;
    bus.req_wen      = wen;
    bus.req_wdata    = wdata;
    bus.req_wmask    = wmask;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_valid    = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (bus.rsp_valid !== 1'b1) lat = -1;
    rdata = bus.rsp_rdata;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    $display("xact addr=%h wen=%0d wdata=%h mask=%b size=%0d uns=%0d -> rdata=%h lat=%0d",
             addr, wen, wdata, wmask, size, uns, rdata, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b expected 1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata: got %h expected 00000000", bus.rsp_rdata); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    int lat;
    xact(BASE, 1'b1, 32'h11223344, 4'hF, 2'b11, 1'b0, rd, lat);
    xact(BASE, 1'b0, 32'h0, 4'h0, 2'b11, 1'b0, rd, lat);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL abort_pre_load: got %h expected 11223344", rd); end
    // Store DEADBEEF, then reset while it is in WAIT.
    bus.req_addr = BASE; bus.req_wen = 1'b1; bus.req_wdata = 32'hDEADBEEF;
    bus.req_wmask = 4'hF; bus.req_size = 2'b11; bus.req_unsigned = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL abort_in_wait: req_ready got %b expected 0", bus.req_ready); end
    rst = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL abort_req_ready: got %b expected 1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_rsp_valid: got %b expected 0", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL abort_rsp_rdata: got %h expected 00000000", bus.rsp_rdata); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    xact(BASE, 1'b0, 32'h0, 4'h0, 2'b11, 1'b0, rd, lat);
    checks++; if (rd === 32'hDEADBEEF) begin errors++; $display("FAIL abort_no_commit: got %h required not deadbeef", rd); end
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL abort_old_data: got %h expected 11223344", rd); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    int lat;
    xact(BASE + 32'h4, 1'b1, 32'h8899AABB, 4'hF, 2'b11, 1'b0, rd, lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL st_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL st_rdata: got %h expected 00000000", rd); end
    xact(BASE + 32'h4, 1'b0, 32'h0, 4'h0, 2'b11, 1'b0, rd, lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL ld_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (rd !== 32'h8899AABB) begin errors++; $display("FAIL ld_word: got %h expected 8899aabb", rd); end
    xact(BASE + 32'h4, 1'b0, 32'h0, 4'h0, 2'b01, 1'b0, rd, lat);
    checks++; if (rd !== 32'hFFFFFFBB) begin errors++; $display("FAIL ld_byte_s: got %h expected ffffffbb", rd); end
    xact(BASE + 32'h5, 1'b0, 32'h0, 4'h0, 2'b01, 1'b0, rd, lat);
    checks++; if (rd !== 32'hFFFFFFAA) begin errors++; $display("FAIL ld_byte1_s: got %h expected ffffffaa", rd); end
    xact(BASE + 32'h7, 1'b0, 32'h0, 4'h0, 2'b01, 1'b1, rd, lat);
    checks++; if (rd !== 32'h00000088) begin errors++; $display("FAIL ld_byte3_u: got %h expected 00000088", rd); end
    xact(BASE + 32'h6, 1'b0, 32'h0, 4'h0, 2'b10, 1'b1, rd, lat);
    checks++; if (rd !== 32'h00008899) begin errors++; $display("FAIL ld_half_u: got %h expected 00008899", rd); end
    xact(BASE + 32'h6, 1'b0, 32'h0, 4'h0, 2'b10, 1'b0, rd, lat);
    checks++; if (rd !== 32'hFFFF8899) begin errors++; $display("FAIL ld_half_s: got %h expected ffff8899", rd); end
    xact(BASE + 32'h4, 1'b0, 32'h0, 4'h0, 2'b00, 1'b0, rd, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ld_size_none: got %h expected 00000000", rd); end
  endtask

  task automatic test_mask();
    logic [31:0] rd;
    int lat;
    xact(BASE + 32'h4, 1'b1, 32'h00110000, 4'b0100, 2'b11, 1'b0, rd, lat);
    xact(BASE + 32'h4, 1'b0, 32'h0, 4'h0, 2'b11, 1'b0, rd, lat);
    checks++; if (rd !== 32'h8811AABB) begin errors++; $display("FAIL mask_lane2: got %h expected 8811aabb", rd); end
    xact(BASE + 32'h4, 1'b1, 32'hFFFFFFFF, 4'b0000, 2'b11, 1'b0, rd, lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL mask_zero_latency: got %0d expected %0d", lat, LAT); end
    xact(BASE + 32'h4, 1'b0, 32'h0, 4'h0, 2'b11, 1'b0, rd, lat);
    checks++; if (rd !== 32'h8811AABB) begin errors++; $display("FAIL mask_zero: got %h expected 8811aabb", rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    int lat;
    int n;
    xact(BASE + 32'h8, 1'b1, 32'h0, 4'hF, 2'b11, 1'b0, rd, lat);
    bus.req_addr = BASE + 32'h4; bus.req_wen = 1'b0; bus.req_size = 2'b11;
    bus.req_unsigned = 1'b0; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    // Competing store presented while the response is stalled.
    bus.req_addr = BASE + 32'h8; bus.req_wen = 1'b1; bus.req_wdata = 32'h12345678;
    bus.req_wmask = 4'hF; bus.req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, bus.rsp_valid); end
      checks++; if (bus.rsp_rdata !== 32'h8811AABB) begin errors++; $display("FAIL bp_rdata[%0d]: got %h expected 8811aabb", c, bus.rsp_rdata); end
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b expected 0", c, bus.req_ready); end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_released: rsp_valid got %b expected 0", bus.rsp_valid); end
    xact(BASE + 32'h8, 1'b0, 32'h0, 4'h0, 2'b11, 1'b0, rd, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL bp_ignored_req: got %h expected 00000000", rd); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    int lat;
    xact(32'h7FFFFFFC, 1'b0, 32'h0, 4'h0, 2'b11, 1'b0, rd, lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL oor_low_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_low: got %h expected 00000000", rd); end
    xact(BASE + 32'(4 * DEPTH), 1'b1, 32'h55555555, 4'hF, 2'b11, 1'b0, rd, lat);
    xact(BASE + 32'(4 * DEPTH), 1'b0, 32'h0, 4'h0, 2'b11, 1'b0, rd, lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL oor_high_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_high: got %h expected 00000000", rd); end
    xact(BASE + 32'(4 * DEPTH - 4), 1'b1, 32'hCAFEF00D, 4'hF, 2'b11, 1'b0, rd, lat);
    xact(BASE + 32'(4 * DEPTH - 4), 1'b0, 32'h0, 4'h0, 2'b11, 1'b0, rd, lat);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL last_word: got %h expected cafef00d", rd); end
    // The dropped high store must not have aliased onto word 0.
    xact(BASE, 1'b0, 32'h0, 4'h0, 2'b11, 1'b0, rd, lat);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL oor_no_alias: got %h expected 11223344", rd); end
  endtask

  task automatic test_back_to_back();
    int acc_cyc [$];
    int rsp_n;
    logic [31:0] rd_seen;
    rsp_n = 0;
    rd_seen = 32'h0;
    bus.req_addr = BASE + 32'h4; bus.req_wen = 1'b0; bus.req_size = 2'b11;
    bus.req_unsigned = 1'b0; bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (bus.req_valid && bus.req_ready) acc_cyc.push_back(k);
      if (bus.rsp_valid && bus.rsp_ready) begin rsp_n++; rd_seen = bus.rsp_rdata; end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
    $display("b2b accepts=%0d responses=%0d last_rdata=%h", acc_cyc.size(), rsp_n, rd_seen);
    checks++; if (acc_cyc.size() !== 3) begin errors++; $display("FAIL b2b_accepts: got %0d expected 3", acc_cyc.size()); end
    checks++; if (rsp_n !== 3) begin errors++; $display("FAIL b2b_responses: got %0d expected 3", rsp_n); end
    if (acc_cyc.size() >= 2) begin
      checks++; if (acc_cyc[1] - acc_cyc[0] !== LAT + 1) begin errors++; $display("FAIL b2b_interval: got %0d expected %0d", acc_cyc[1] - acc_cyc[0], LAT + 1); end
    end
    checks++; if (rd_seen !== 32'h8811AABB) begin errors++; $display("FAIL b2b_rdata: got %h expected 8811aabb", rd_seen); end
  endtask

`ifdef YSYX_23060042_DMEM_MISALIGN_CHK_EN
  task automatic test_misalign();
    logic [31:0] rd;
    int lat;
    logic err;
    xact(BASE + 32'h2, 1'b0, 32'h0, 4'h0, 2'b11, 1'b0, rd, lat);
    err = bus.rsp_err;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b expected 1", err); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_rdata: got %h expected 00000000", rd); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL mis_latency: got %0d expected %0d", lat, LAT); end
    xact(BASE + 32'h5, 1'b1, 32'h0000FF00, 4'b0010, 2'b10, 1'b0, rd, lat);
    xact(BASE + 32'h4, 1'b0, 32'h0, 4'h0, 2'b11, 1'b0, rd, lat);
    err = bus.rsp_err;
    checks++; if (rd !== 32'h8811AABB) begin errors++; $display("FAIL mis_store_suppressed: got %h expected 8811aabb", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mis_err_clear: got %b expected 0", err); end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wen      = 1'b0;
    bus.req_wdata    = 32'h0;
    bus.req_wmask    = 4'h0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.rsp_ready    = 1'b0;
    test_reset();
    test_reset_abort();
    test_store_load();
    test_mask();
    test_backpressure();
    test_out_of_range();
    test_back_to_back();
`ifdef YSYX_23060042_DMEM_MISALIGN_CHK_EN
    test_misalign();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
